// File: rtl/key_bounce_gen_if.sv
// ---------------------------------------------------------------------------
// key_bounce_gen_if
// Command/status bundle of the mechanical-key emulator.
//   req_valid  requester -> emulator   command valid
//   req_press  requester -> emulator   1 = press (line low), 0 = release (line high)
//   req_ready  emulator  -> requester  emulator idle, command can be taken
//   key_out    emulator  -> requester  emulated active-low key line
//   busy       emulator  -> requester  command in progress
//   done       emulator  -> requester  one-cycle completion pulse
//   edge_cnt   emulator  -> requester  key_out transitions of current/last command
// The master modport is the command source; the slave modport is the emulator.
// ---------------------------------------------------------------------------
interface key_bounce_gen_if;
  logic       req_valid;
  logic       req_press;
  logic       req_ready;
  logic       key_out;
  logic       busy;
  logic       done;
  logic [7:0] edge_cnt;

  modport master (
    output req_valid,
    output req_press,
    input  req_ready,
    input  key_out,
    input  busy,
    input  done,
    input  edge_cnt
  );

  modport slave (
    input  req_valid,
    input  req_press,
    output req_ready,
    output key_out,
    output busy,
    output done,
    output edge_cnt
  );
endinterface

// File: rtl/key_bounce_gen.sv
// ---------------------------------------------------------------------------
// key_bounce_gen
// Synthesizable mechanical-key emulator. On each accepted command it drives
// an active-low key line towards the requested level through a pseudo-random
// bounce burst, then holds the line stable for a settle window and pulses
// done. Intended as stimulus for the key debouncer.
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    key_bounce_gen_if.slave (req_valid/req_press in; req_ready,
//          key_out, busy, done, edge_cnt out, all registered)
// Parameters:
//   BOUNCE_CYCLES  clocks of bouncing per transition (>=1)
//   SETTLE_CYCLES  clocks the line is held at target before done (>=1)
//   GAP_W          width of the random inter-toggle gap (1..2^GAP_W-1 clocks)
//   LFSR_SEED      LFSR reset value; zero is replaced by 16'h0001
// ---------------------------------------------------------------------------
module key_bounce_gen #(
  parameter int          BOUNCE_CYCLES = 200,
  parameter int          SETTLE_CYCLES = 1000,
  parameter int          GAP_W         = 4,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  key_bounce_gen_if.slave  bus
);

  localparam int BCNT_W = $clog2(BOUNCE_CYCLES + 1);
  localparam int SCNT_W = $clog2(SETTLE_CYCLES + 1);

  // A zero seed would lock the Galois LFSR at zero forever.
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  localparam logic [BCNT_W-1:0] BCNT_LOAD = BCNT_W'(BOUNCE_CYCLES - 1);
  localparam logic [SCNT_W-1:0] SCNT_LOAD = SCNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state_q;
  logic              key_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic              target_q;
  logic [7:0]        edge_q;
  logic [15:0]       lfsr_q;
  logic [15:0]       lfsr_d;
  logic [BCNT_W-1:0] bcnt_q;
  logic [SCNT_W-1:0] scnt_q;
  logic [GAP_W-1:0]  gap_q;
  logic [GAP_W-1:0]  gap_d;
  logic [7:0]        edge_inc;
  logic              cmd_target;

  // Galois right-shift step with mask 16'hB400; the LFSR runs in every state
  // so the random sequence depends only on time since reset.
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // Next inter-toggle gap taken from the current LFSR value; a zero gap
  // would never expire, so it is bumped to one.
  assign gap_d = (lfsr_q[GAP_W-1:0] == '0) ? GAP_W'(1) : lfsr_q[GAP_W-1:0];

  // Saturating edge counter increment.
  assign edge_inc = (edge_q == 8'hFF) ? edge_q : edge_q + 8'd1;

  // Released key (press=0) targets a high line; pressed key targets low.
  assign cmd_target = ~bus.req_press;

  // Single FSM process; every output is a register updated together with
  // the state so the outputs always describe the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      key_q    <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      target_q <= 1'b1;
      edge_q   <= 8'd0;
      lfsr_q   <= SEED;
      bcnt_q   <= '0;
      scnt_q   <= '0;
      gap_q    <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      case (state_q)
        IDLE: begin
          if (bus.req_valid && ready_q) begin
            target_q <= cmd_target;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            if (cmd_target == key_q) begin
              // Already at the requested level: complete without edges.
              state_q <= DONE;
              done_q  <= 1'b1;
              edge_q  <= 8'd0;
            end else begin
              // The first bounce edge happens on the accepting edge itself.
              state_q <= BOUNCE;
              key_q   <= ~key_q;
              edge_q  <= 8'd1;
              bcnt_q  <= BCNT_LOAD;
              gap_q   <= gap_d;
            end
          end
        end

        BOUNCE: begin
          if (bcnt_q != '0) begin
            bcnt_q <= bcnt_q - BCNT_W'(1);
            if (gap_q == GAP_W'(1)) begin
              key_q  <= ~key_q;
              edge_q <= edge_inc;
              gap_q  <= gap_d;
            end else begin
              gap_q <= gap_q - GAP_W'(1);
            end
          end else begin
            // End of the burst: land on the target, counting the edge only
            // if the line really moves.
            if (key_q != target_q) begin
              key_q  <= target_q;
              edge_q <= edge_inc;
            end
            state_q <= SETTLE;
            scnt_q  <= SCNT_LOAD;
          end
        end

        SETTLE: begin
          if (scnt_q == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            scnt_q <= scnt_q - SCNT_W'(1);
          end
        end

        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end

        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.key_out   = key_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.edge_cnt  = edge_q;

endmodule

// File: tb/tb_key_bounce_gen.sv
// ---------------------------------------------------------------------------
// tb_key_bounce_gen
// Self-checking bench for key_bounce_gen. A reference model predicts, for
// every command, the full key_out waveform as a schedule of toggle times
// derived from the free-running LFSR, plus edge count and done timing.
// A simple counting debouncer watches key_out to count press events.
// ---------------------------------------------------------------------------
module tb_key_bounce_gen;

  localparam int          B    = 200;
  localparam int          S    = 1000;
  localparam int          GW   = 4;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          DEB  = 30;

  logic clk;
  logic rst_n;

  key_bounce_gen_if bus ();

  key_bounce_gen #(
    .BOUNCE_CYCLES (B),
    .SETTLE_CYCLES (S),
    .GAP_W         (GW),
    .LFSR_SEED     (SEED)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          checks;
  int          failures;
  logic [15:0] modelLfsr;
  bit          modelKey;
  bit          expWave  [B];
  bit          obsWave  [B];
  bit          savedWave[B];
  int          pressEvents;
  bit          debLevel;
  bit          lastKey;
  int          stableCnt;

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsrStep(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int gapOf(input logic [15:0] l);
    int g;
    g = int'(l[GW-1:0]);
    return (g == 0) ? 1 : g;
  endfunction

  // Reference LFSR: advances every clock since reset, regardless of state.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) modelLfsr <= SEED;
    else        modelLfsr <= lfsrStep(modelLfsr);
  end

  // Counting debouncer: a level is accepted after DEB stable clocks, longer
  // than any possible bounce gap.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      debLevel  <= 1'b1;
      lastKey   <= 1'b1;
      stableCnt <= 0;
    end else begin
      lastKey <= bus.key_out;
      if (bus.key_out != lastKey) stableCnt <= 0;
      else if (stableCnt < DEB)   stableCnt <= stableCnt + 1;
      if (stableCnt == DEB && lastKey != debLevel) begin
        debLevel <= lastKey;
        if (lastKey == 1'b0) pressEvents <= pressEvents + 1;
      end
    end
  end

  // One comparison point: counts it and reports on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Holds reset for 5 clocks and releases it on a falling edge, then idles
  // a fixed number of clocks so command timing relative to reset repeats.
  task automatic doReset();
    rst_n = 1'b0;
    modelKey = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Issues one command starting at a falling edge and follows it to the
  // first IDLE cycle after done, comparing against the model every clock.
  // With keepValid the request stays asserted after acceptance.
  task automatic applyStimulus(input string tag, input bit press, input bit keepValid);
    int          waitCnt;
    logic [15:0] lf;
    bit          lvl;
    bit          target;
    bit          expKey;
    int          edges;
    int          nxt;
    int          doneOff;
    int          waveErr;
    int          hsErr;
    int          doneErr;
    bus.req_valid = 1'b1;
    bus.req_press = press;
    waitCnt = 0;
    while (bus.req_ready !== 1'b1 && waitCnt < 3000) begin
      @(negedge clk);
      waitCnt++;
    end
    if (bus.req_ready !== 1'b1) begin
      checkOutput({tag, "_acceptTimeout"}, 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    // Model: toggle schedule t0=0, t(i+1)=t(i)+gap(LFSR at t(i)) within the burst.
    lf     = modelLfsr;
    lvl    = modelKey;
    target = ~press;
    edges  = 0;
    nxt    = 0;
    if (target != lvl) begin
      for (int k = 0; k < B; k++) begin
        if (k == nxt) begin
          lvl = ~lvl;
          edges++;
          nxt = k + gapOf(lf);
        end
        expWave[k] = lvl;
        lf = lfsrStep(lf);
      end
      if (lvl != target) edges++;
      if (edges > 255) edges = 255;
      doneOff = B + S;
    end else begin
      doneOff = 0;
    end
    waveErr = 0;
    hsErr   = 0;
    doneErr = 0;
    @(posedge clk);
    @(negedge clk);
    if (!keepValid) bus.req_valid = 1'b0;
    for (int k = 0; k <= doneOff + 1; k++) begin
      expKey = (doneOff != 0 && k < B) ? expWave[k] : target;
      if (k < B) obsWave[k] = bus.key_out;
      if (bus.key_out !== expKey) waveErr++;
      if (k <= doneOff) begin
        if (bus.req_ready !== 1'b0 || bus.busy !== 1'b1) hsErr++;
        if (bus.done !== ((k == doneOff) ? 1'b1 : 1'b0)) doneErr++;
      end else begin
        if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) hsErr++;
        if (bus.done !== 1'b0) doneErr++;
      end
      if (k != doneOff + 1) @(negedge clk);
    end
    checkOutput({tag, "_waveErrs"}, waveErr, 0);
    checkOutput({tag, "_handshakeErrs"}, hsErr, 0);
    checkOutput({tag, "_doneTimingErrs"}, doneErr, 0);
    checkOutput({tag, "_edgeCnt"}, bus.edge_cnt, edges);
    checkOutput({tag, "_edgeParity"}, bus.edge_cnt[0], (edges > 0) ? 1 : 0);
    checkOutput({tag, "_finalKey"}, bus.key_out, target);
    modelKey = target;
  endtask

  initial begin
    int doneSeen;
    int keyMoves;
    int waveDiff;
    int baseEvents;
    bit prevKey;
    checks        = 0;
    failures      = 0;
    pressEvents   = 0;
    bus.req_valid = 1'b0;
    bus.req_press = 1'b0;
    rst_n         = 1'b1;
    #2;

    // Test 1: reset state.
    $display("[TB] reset idle");
    doReset();
    checkOutput("rst_key", bus.key_out, 1);
    checkOutput("rst_ready", bus.req_ready, 1);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_edgeCnt", bus.edge_cnt, 0);

    // Test 2: press with defaults; waveform kept for the determinism check.
    $display("[TB] press");
    applyStimulus("press", 1'b1, 1'b0);
    savedWave = obsWave;

    // Test 3: release.
    $display("[TB] release");
    applyStimulus("release", 1'b0, 1'b0);

    // Test 4: press, then a redundant press.
    $display("[TB] redundant press");
    applyStimulus("press2", 1'b1, 1'b0);
    applyStimulus("redundant", 1'b1, 1'b0);

    // Test 5: request held through a busy command; exactly one more runs.
    $display("[TB] held request");
    applyStimulus("heldFirst", 1'b0, 1'b1);
    applyStimulus("heldSecond", 1'b1, 1'b0);
    doneSeen = 0;
    keyMoves = 0;
    prevKey  = bus.key_out;
    repeat (50) begin
      @(negedge clk);
      if (bus.done === 1'b1) doneSeen++;
      if (bus.key_out !== prevKey) keyMoves++;
      prevKey = bus.key_out;
    end
    checkOutput("held_extraDone", doneSeen, 0);
    checkOutput("held_keyMoves", keyMoves, 0);

    // Test 6: reset in the middle of a bounce burst, then rerun the press.
    $display("[TB] reset mid-bounce");
    bus.req_valid = 1'b1;
    bus.req_press = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midRst_key", bus.key_out, 1);
    checkOutput("midRst_busy", bus.busy, 0);
    checkOutput("midRst_done", bus.done, 0);
    checkOutput("midRst_ready", bus.req_ready, 1);
    @(negedge clk);
    doReset();
    applyStimulus("rerun", 1'b1, 1'b0);
    waveDiff = 0;
    for (int k = 0; k < B; k++) if (obsWave[k] != savedWave[k]) waveDiff++;
    checkOutput("rerun_identical", waveDiff, 0);

    // Test 7: ten press/release pairs through the debouncer.
    $display("[TB] debouncer loop");
    applyStimulus("loopPre", 1'b0, 1'b0);
    baseEvents = pressEvents;
    for (int i = 0; i < 10; i++) begin
      applyStimulus("loopPress", 1'b1, 1'b0);
      applyStimulus("loopRelease", 1'b0, 1'b0);
    end
    checkOutput("loop_pressEvents", pressEvents - baseEvents, 10);

    // Randomized commands with random idle gaps.
    $display("[TB] random commands");
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      applyStimulus("random", 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
